timer_unit: RTL and testbench

TIMER_UNIT -- requirements
Module: timer_unit

---
 rtl/timer_unit.sv | 144 ++++++++++++++
 tb/tb_timer_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_unit.sv
// Shared free-running divider plus CHANNELS TIMA/TMA/TAC counters behind an 8-bit register port.
// Build macro TIMER_RELOAD_DELAY_EN: overflow reload and irq land one cycle after the wrap, cancellable by a TIMA write.
module timer_unit #(
    parameter int CHANNELS = 1,
    parameter int DIV_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                rd_en,
    input  logic [4:0]          addr,
    input  logic [7:0]          wdata,
    output logic [7:0]          rdata,
    output logic [CHANNELS-1:0] irq,
    input  logic [CHANNELS-1:0] irq_ack
);
    logic [DIV_W-1:0] divider;
    logic             div_wr;
    logic [7:0]       tima_rd [CHANNELS];
    logic [7:0]       tma_rd  [CHANNELS];
    logic [2:0]       tac_rd  [CHANNELS];
    logic [7:0]       rd_val;
    logic             unused_div;

    assign div_wr     = wr_en && (addr == 5'd0);
    assign unused_div = ^divider;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            divider <= '0;
        else if (div_wr)
            divider <= '0;
        else
            divider <= divider + DIV_W'(1);
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        localparam logic [4:0] A_TIMA = 5'(1 + 3 * k);
        localparam logic [4:0] A_TMA  = 5'(2 + 3 * k);
        localparam logic [4:0] A_TAC  = 5'(3 + 3 * k);

        logic [7:0] tima;
        logic [7:0] tma;
        logic [2:0] tac;
        logic       tap;
        logic       sig;
        logic       sig_q;
        logic       fall;
        logic       set;
        logic       irq_q;
        logic       wr_tima;
        logic       wr_tma;
        logic [7:0] tma_eff;

        always_comb begin
            case (tac[1:0])
                2'b00:   tap = divider[9];
                2'b01:   tap = divider[3];
                2'b10:   tap = divider[5];
                default: tap = divider[7];
            endcase
        end

        // Edge detect on the gated tap, so DIV clears, disables and tap switches all count.
        assign sig     = tac[2] & tap;
        assign fall    = sig_q & ~sig;
        assign wr_tima = wr_en && (addr == A_TIMA);
        assign wr_tma  = wr_en && (addr == A_TMA);
        assign tma_eff = wr_tma ? wdata : tma;

`ifdef TIMER_RELOAD_DELAY_EN
        logic pend;
        assign set = pend & ~wr_tima;
`else
        assign set = fall && (tima == 8'hFF) && !wr_tima;
`endif

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tima  <= 8'h00;
                tma   <= 8'h00;
                tac   <= 3'b000;
                sig_q <= 1'b0;
                irq_q <= 1'b0;
`ifdef TIMER_RELOAD_DELAY_EN
                pend  <= 1'b0;
`endif
            end else begin
                sig_q <= sig;
                irq_q <= (irq_q & ~irq_ack[k]) | set;
                if (wr_tma)
                    tma <= wdata;
                if (wr_en && (addr == A_TAC))
                    tac <= wdata[2:0];
`ifdef TIMER_RELOAD_DELAY_EN
                pend <= 1'b0;
                if (wr_tima)
                    tima <= wdata;
                else if (pend)
                    tima <= tma_eff;
                else if (fall) begin
                    if (tima == 8'hFF) begin
                        tima <= 8'h00;
                        pend <= 1'b1;
                    end else begin
                        tima <= tima + 8'd1;
                    end
                end
`else
                if (wr_tima)
                    tima <= wdata;
                else if (fall)
                    tima <= (tima == 8'hFF) ? tma_eff : tima + 8'd1;
`endif
            end
        end

        assign tima_rd[k] = tima;
        assign tma_rd[k]  = tma;
        assign tac_rd[k]  = tac;
        assign irq[k]     = irq_q;
    end

    always_comb begin
        rd_val = 8'hFF;
        if (addr == 5'd0)
            rd_val = divider[DIV_W-1 -: 8];
        for (int k = 0; k < CHANNELS; k++) begin
            if (addr == 5'(1 + 3 * k))
                rd_val = tima_rd[k];
            if (addr == 5'(2 + 3 * k))
                rd_val = tma_rd[k];
            if (addr == 5'(3 + 3 * k))
                rd_val = {5'b11111, tac_rd[k]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= 8'h00;
        else if (rd_en)
            rdata <= rd_val;
    end
endmodule

// File: tb/tb_timer_unit.sv
// Randomized bench for timer_unit: an arithmetic reference model feeds a scoreboard that a negedge monitor drains.
module tb_timer_unit;
    localparam int CH = 2;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [4:0]    addr = 5'd0;
    logic [7:0]    wdata = 8'd0;
    logic [7:0]    rdata;
    logic [CH-1:0] irq;
    logic [CH-1:0] irq_ack = '0;

    timer_unit #(.CHANNELS(CH), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
        .wdata(wdata), .rdata(rdata), .irq(irq), .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state: what the registers hold right now.
    int            m_div;
    int            m_tima [CH];
    int            m_tma  [CH];
    int            m_tac  [CH];
    bit            m_prev [CH];
    bit            m_pend [CH];
    logic [CH-1:0] m_irq = '0;
    logic [CH-1:0] m_set;
    bit            rd_seen = 1'b0;

    typedef struct packed { int at; logic [CH-1:0] v; } irq_exp_t;
    logic [7:0] rd_q [$];
    irq_exp_t   irq_q [$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h, want %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got no event within budget, want event at %0t", name, $time);
    endtask

    // Tap periods in cycles: bit9 -> 1024, bit3 -> 16, bit5 -> 64, bit7 -> 256.
    function automatic int half_period(input int t);
        case (t & 3)
            0:       return 512;
            1:       return 8;
            2:       return 32;
            default: return 128;
        endcase
    endfunction

    function automatic bit m_sig(input int k);
        return ((m_tac[k] & 4) != 0) && (((m_div / half_period(m_tac[k])) % 2) == 1);
    endfunction

    function automatic logic [7:0] m_read(input int a);
        if (a == 0) return 8'((m_div >> (DW - 8)) & 255);
        for (int k = 0; k < CH; k++) begin
            if (a == 1 + 3 * k) return 8'(m_tima[k]);
            if (a == 2 + 3 * k) return 8'(m_tma[k]);
            if (a == 3 + 3 * k) return 8'(248 | m_tac[k]);
        end
        return 8'hFF;
    endfunction

    // True when the model will raise irq[k] at the coming edge, absent a TIMA write.
    function automatic bit will_irq(input int k);
`ifdef TIMER_RELOAD_DELAY_EN
        return m_pend[k];
`else
        return m_prev[k] && !m_sig(k) && (m_tima[k] == 255);
`endif
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_div   = 0;
            m_irq   = '0;
            rd_seen = 1'b0;
            for (int k = 0; k < CH; k++) begin
                m_tima[k] = 0; m_tma[k] = 0; m_tac[k] = 0;
                m_prev[k] = 1'b0; m_pend[k] = 1'b0;
            end
        end else begin
            rd_seen = rd_en;
            m_set   = '0;
            for (int k = 0; k < CH; k++) begin
                int base;
                int ntma;
                bit s;
                bit fall;
                base = 1 + 3 * k;
                s    = m_sig(k);
                fall = m_prev[k] && !s;
                ntma = (wr_en && addr == base + 1) ? int'(wdata) : m_tma[k];
                if (wr_en && addr == base) begin
                    m_tima[k] = wdata;
                    m_pend[k] = 1'b0;
                end else if (m_pend[k]) begin
                    m_tima[k] = ntma;
                    m_pend[k] = 1'b0;
                    m_set[k]  = 1'b1;
                end else if (fall) begin
                    if (m_tima[k] == 255) begin
`ifdef TIMER_RELOAD_DELAY_EN
                        m_tima[k] = 0;
                        m_pend[k] = 1'b1;
`else
                        m_tima[k] = ntma;
                        m_set[k]  = 1'b1;
`endif
                    end else begin
                        m_tima[k] = m_tima[k] + 1;
                    end
                end
                m_tma[k] = ntma;
                if (wr_en && addr == base + 2) m_tac[k] = wdata & 7;
                m_prev[k] = s;
            end
            m_irq = (m_irq & ~irq_ack) | m_set;
            m_div = (wr_en && addr == 0) ? 0 : (m_div + 1) % (1 << DW);
        end
    end

    always @(negedge clk) begin
        irq_exp_t e;
        if (rst) begin
            check("rst_rdata", rdata, 8'h00);
            check("rst_irq", 8'(irq), 8'h00);
        end else begin
            if (rd_seen) begin
                if (rd_q.size() == 0) timeout("rd_queue_empty");
                else check("rdata", rdata, rd_q.pop_front());
            end
            check("irq_model", 8'(irq), 8'(m_irq));
            while (irq_q.size() > 0 && irq_q[0].at <= cyc) begin
                e = irq_q.pop_front();
                if (e.at == cyc) check("irq_spec", 8'(irq), 8'(e.v));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        irq_ack = '0;
    endtask

    task automatic wr(input int a, input int d);
        addr = 5'(a); wdata = 8'(d); wr_en = 1'b1;
        tick();
    endtask

    task automatic rd_k(input int a, input logic [7:0] k);
        addr = 5'(a); rd_en = 1'b1;
        rd_q.push_back(k);
        tick();
    endtask

    task automatic expect_irq(input logic [CH-1:0] v);
        irq_q.push_back('{at: cyc + 1, v: v});
    endtask

    initial begin
        int n;
        int v;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state of registers.
        rd_k(3, 8'hF8);
        rd_k(0, 8'h00);
        rd_k(1, 8'h00);
        rd_k(7, 8'hFF);

        // Overflow with reload from TMA, then acknowledge.
        wr(2, 8'hA0);
        wr(1, 8'hFF);
        wr(3, 8'h05);
        n = 0;
        while (!will_irq(0) && n < 300) begin tick(); n++; end
        if (n >= 300) timeout("ovf0_wait");
        expect_irq(2'b01);
`ifdef TIMER_RELOAD_DELAY_EN
        rd_k(1, 8'h00);
`else
        tick();
`endif
        rd_k(1, 8'hA0);
        irq_ack = 2'b01;
        expect_irq(2'b00);
        tick();

`ifdef TIMER_RELOAD_DELAY_EN
        // A TIMA write in the pending cycle cancels reload and irq.
        wr(1, 8'hFF);
        n = 0;
        while (!m_pend[0] && n < 300) begin tick(); n++; end
        if (n >= 300) timeout("pend_wait");
        expect_irq(2'b00);
        wr(1, 8'h33);
        rd_k(1, 8'h33);
`endif

        // DIV write with the tap high produces exactly one increment.
        wr(1, 8'h40);
        n = 0;
        while (!((m_div % 16) >= 8 && (m_div % 16) <= 14) && n < 100) begin tick(); n++; end
        if (n >= 100) timeout("div_phase_wait");
        v = m_tima[0];
        wr(0, 8'h5A);
        tick();
        rd_k(1, 8'(v + 1));
        rd_k(0, 8'h00);

        // ch1 overflow on the same edge as an ack of ch0.
        wr(1, 8'hFF);
        n = 0;
        while (!m_irq[0] && n < 300) begin tick(); n++; end
        if (n >= 300) timeout("ovf0_again_wait");
        wr(3, 8'h00);
        wr(4, 8'hFF);
        wr(6, 8'h04);
        n = 0;
        while (!will_irq(1) && n < 2500) begin tick(); n++; end
        if (n >= 2500) timeout("ovf1_wait");
        irq_ack = 2'b01;
        expect_irq(2'b10);
        tick();
        irq_ack = 2'b10;
        expect_irq(2'b00);
        tick();

        for (int i = 0; i < 6000; i++) begin
            int r;
            int a;
            int d;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 15) == 0) irq_ack = 2'($urandom_range(1, 3));
            if (r < 10) begin
                a = $urandom_range(0, 9);
                d = $urandom_range(0, 255);
                if ((a == 1 || a == 4) && r < 6) d = $urandom_range(240, 255);
                if ((a == 3 || a == 6) && r < 7) d = 5;
                addr = 5'(a); wdata = 8'(d); wr_en = 1'b1;
                if (r < 2) begin
                    rd_en = 1'b1;
                    rd_q.push_back(m_read(a));
                end
            end else if (r < 35) begin
                a = $urandom_range(0, 31);
                addr = 5'(a); rd_en = 1'b1;
                rd_q.push_back(m_read(a));
            end
            tick();
        end
        repeat (2) tick();

        // Reset asserted while an overflow is imminent: no irq afterwards.
        wr(3, 8'h05);
        wr(1, 8'hFF);
        n = 0;
        while (!will_irq(0) && n < 300) begin tick(); n++; end
        if (n >= 300) timeout("ovf_before_rst_wait");
        #2 rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expect_irq(2'b00);
            tick();
        end
        rd_k(1, 8'h00);
        rd_k(3, 8'hF8);
        repeat (3) tick();

        if (rd_q.size() != 0) timeout("rd_queue_drain");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
